// File: rtl/input_conditioner.sv
// Purpose: 2-flop synchronize, debounce and press-detect 3 slide switches and 2 push buttons.
// Latency: a steady raw level reaches sw_clean/btn_clean DEBOUNCE_CYCLES+1 edges after it is first sampled.
// Backpressure: none; free-running, every channel accepts a new level every cycle.
// Optional feature macro: INPUT_CONDITIONER_PRESS_EN enables the btn_press strobe (tied to 0 otherwise).
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sw_raw,
    input  logic [1:0] btn_raw,
    output logic [2:0] sw_clean,
    output logic [1:0] btn_clean,
    output logic [1:0] btn_press
);

    localparam int NCH = 5;
    // Terminal count: the edge that sees cnt at this value commits the new level.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order: switches in [2:0], buttons in [4:3].
    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync1;
    logic [NCH-1:0]   sync2;
    logic [NCH-1:0]   clean;
    logic [CNT_W-1:0] cnt [NCH];

    assign raw = {btn_raw, sw_raw};

    // Two-stage synchronizer for every asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce: count consecutive disagreeing cycles, commit on terminal count,
    // and throw away any partial count as soon as the input agrees with clean again.
    always_ff @(posedge clk) begin
        if (rst) begin
            clean <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= CNT_MAX) begin
                    clean[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign sw_clean  = clean[2:0];
    assign btn_clean = clean[4:3];

`ifdef INPUT_CONDITIONER_PRESS_EN
    logic [1:0] btn_rise;
    logic [1:0] btn_press_q;

    // A button rises exactly when its debouncer commits a 0->1 update on this edge.
    always_comb begin
        btn_rise = '0;
        for (int i = 0; i < 2; i++) begin
            btn_rise[i] = sync2[i+3] & ~clean[i+3] & (cnt[i+3] >= CNT_MAX);
        end
    end

    // Strobe register lines up with the first cycle btn_clean reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_press_q <= '0;
        end else begin
            btn_press_q <= btn_rise;
        end
    end

    assign btn_press = btn_press_q;
`else
    assign btn_press = 2'b00;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
// Press expectations follow whether INPUT_CONDITIONER_PRESS_EN is defined for the build.
module tb_input_conditioner;

`ifdef INPUT_CONDITIONER_PRESS_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] sw_raw;
    logic [1:0] btn_raw;
    logic [2:0] sw_clean;
    logic [1:0] btn_clean;
    logic [1:0] btn_press;

    int n_cmp = 0;
    int n_bad = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .btn_raw   (btn_raw),
        .sw_clean  (sw_clean),
        .btn_clean (btn_clean),
        .btn_press (btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] press_exp;
        logic [4:0] bounce;
        int pulses;
        int first;
        logic any;

        press_exp = PE ? 2'b11 : 2'b00;

        // Reset with every raw input held high.
        rst = 1'b1;
        sw_raw = 3'b111;
        btn_raw = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("rst_sw", 8'(sw_clean), 8'h0);
            chk("rst_btn", 8'(btn_clean), 8'h0);
            chk("rst_press", 8'(btn_press), 8'h0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) chk("rel_sw_early", 8'(sw_clean), 8'h0);
            if (k == 6) begin
                chk("rel_sw", 8'(sw_clean), 8'h7);
                chk("rel_btn", 8'(btn_clean), 8'h3);
                chk("rel_press", 8'(btn_press), 8'(press_exp));
            end
            if (k == 7) chk("rel_press_end", 8'(btn_press), 8'h0);
        end

        // Falling path back to all-zero must never strobe.
        sw_raw = 3'b000;
        btn_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("fall_press", 8'(btn_press), 8'h0);
        end
        chk("fall_sw", 8'(sw_clean), 8'h0);
        chk("fall_btn", 8'(btn_clean), 8'h0);

        // Clean step on sw_raw[0].
        sw_raw = 3'b001;
        tick();
        repeat (4) tick();
        chk("step_early", 8'(sw_clean), 8'h0);
        tick();
        chk("step_sw", 8'(sw_clean), 8'h1);
        chk("step_btn", 8'(btn_clean), 8'h0);

        // Bounce on btn_raw[0]: 1,0,1,0 then hold 1.
        bounce = 5'b10101;
        for (int k = 0; k < 5; k++) begin
            btn_raw[0] = bounce[k];
            tick();
            chk("bounce_hold", 8'(btn_clean), 8'h0);
        end
        pulses = 0;
        first = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            pulses += int'(btn_press[0]);
            if (first == 0 && btn_clean[0] === 1'b1) first = k;
            if (k == 4) chk("bounce_early", 8'(btn_clean), 8'h0);
            if (k == 5) chk("bounce_press", 8'(btn_press), PE ? 8'h1 : 8'h0);
            if (k == 6) chk("bounce_press_end", 8'(btn_press), 8'h0);
        end
        chk("bounce_latency", 8'(first), 8'd5);
        chk("bounce_pulses", 8'(pulses), PE ? 8'd1 : 8'd0);

        // Three-cycle glitch on btn_raw[1] must be rejected.
        any = 1'b0;
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            if (k == 4) btn_raw[1] = 1'b0;
            tick();
            any = any | btn_clean[1] | btn_press[1];
        end
        chk("glitch_any", 8'(any), 8'h0);
        chk("glitch_btn", 8'(btn_clean), 8'h1);
        chk("glitch_sw", 8'(sw_clean), 8'h1);

        // Release btn 0, start sw 1, then reset while both are mid-count.
        btn_raw[0] = 1'b0;
        sw_raw = 3'b011;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("drop_press", 8'(btn_press), 8'h0);
            chk("drop_btn", 8'(btn_clean), 8'h1);
        end
        rst = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk("mid_rst_sw", 8'(sw_clean), 8'h0);
            chk("mid_rst_btn", 8'(btn_clean), 8'h0);
            chk("mid_rst_press", 8'(btn_press), 8'h0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) chk("restart_early", 8'(sw_clean), 8'h0);
            if (k == 6) begin
                chk("restart_sw", 8'(sw_clean), 8'h3);
                chk("restart_btn", 8'(btn_clean), 8'h0);
                chk("restart_press", 8'(btn_press), 8'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive clk cycles a synchronized input must differ from its clean value before the clean value updates (legal range 2..65535).
REQ-002 Parameter CNT_W, default 16: width of each debounce counter; SHALL satisfy 2**CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sw_raw  input  3  asynchronous slide-switch levels, bit i = switch i.
REQ-006 btn_raw  input  2  asynchronous push-button levels, 1 = pressed.
REQ-007 sw_clean  output  3  synchronized, debounced switch levels, registered; feeds the downstream LED controller's switches input.
REQ-008 btn_clean  output  2  synchronized, debounced button levels, registered; feeds the downstream LED controller's buttons input.
REQ-009 btn_press  output  2  one-cycle press strobe per button, registered.

Function
REQ-010 Each of the 5 raw inputs SHALL pass through its own 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-011 Each input SHALL have an independent debounce counter cnt[CNT_W-1:0] and clean register; channels SHALL NOT interact.
REQ-012 Per edge, if sync2 == clean: cnt <= 0, clean holds.
REQ-013 Per edge, if sync2 != clean and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1, clean holds.
REQ-014 Per edge, if sync2 != clean and cnt == DEBOUNCE_CYCLES-1: clean <= sync2, cnt <= 0.
REQ-015 Latency: a raw level first sampled into sync1 at edge E and held steady SHALL appear on the clean output after edge E+DEBOUNCE_CYCLES+1.
REQ-016 Glitch rejection: any return of sync2 to the clean value before the count completes SHALL clear cnt; the partial count is discarded, never resumed.
REQ-017 Counters SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL NOT wrap.
REQ-018 btn_press[i] SHALL be 1 for exactly the single cycle in which btn_clean[i] first reads 1 after a 0->1 update, and 0 otherwise.
REQ-019 No btn_press pulse SHALL be generated on a 1->0 transition of btn_clean.
REQ-020 Simultaneous transitions on several inputs SHALL each be debounced independently with identical latency.

Reset
REQ-021 While rst=1 at a clk edge, all sync flops, counters, sw_clean, btn_clean and btn_press SHALL be 0.
REQ-022 Reset asserted mid-debounce SHALL discard the count; after release, counting restarts from 0 against clean=0.
REQ-023 An input held at 1 through reset release SHALL reach clean=1 after DEBOUNCE_CYCLES+2 edges following the first non-reset edge, with a btn_press pulse for buttons.

Configuration
REQ-024 Macro INPUT_CONDITIONER_PRESS_EN: when defined, btn_press behaves per REQ-018/019.
REQ-025 When INPUT_CONDITIONER_PRESS_EN is undefined, the btn_press port SHALL still exist, be driven constant 0, and no edge-detect flops SHALL be synthesized; all other behaviour is unchanged.

Verification (bench uses DEBOUNCE_CYCLES=4, 10 ns clk, PRESS_EN defined unless stated)
REQ-026 Reset: rst=1 for 3 edges, all raw inputs 1 -> sw_clean=000, btn_clean=00, btn_press=00 during reset; after release, sw_clean=111 after 6th edge.
REQ-027 Clean step: sw_raw[0] 0->1 sampled at edge E, held -> sw_clean[0]=1 after edge E+5, not before; other bits stay 0.
REQ-028 Bounce: btn_raw[0] toggles 1,0,1,0 at one-cycle intervals then holds 1 -> btn_clean[0] rises only 5 edges after the final 1 is sampled; exactly one btn_press[0] pulse, one cycle wide.
REQ-029 Short glitch: btn_raw[1]=1 for 3 cycles then 0 -> btn_clean[1] and btn_press[1] stay 0 throughout.
REQ-030 Release and mid-reset: hold btn_raw[0]=1 until btn_clean[0]=1, drop to 0, assert rst 2 cycles after the drop -> no btn_press on the falling path, btn_clean[0]=0 from reset, counter restarts at 0.
REQ-031 Build with INPUT_CONDITIONER_PRESS_EN undefined, repeat REQ-028 stimulus -> btn_clean[0] identical timing, btn_press=00 for the whole run.
